ifu_fetch_stage: RTL and testbench



---
 rtl/ifu_fetch_stage.sv | 88 ++++++++
 tb/tb_ifu_fetch_stage.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_stage.sv
// Instruction-fetch stage: issues requests to a 1-cycle-latency instruction SRAM,
// presents pc/inst to decode, holds the word across back-pressure, redirects on taken branches.
module ifu_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    input  logic        IDU_allow_in,
    output logic        IFU_to_IDU_valid,
    output logic [31:0] pc_from_IFU,
    output logic [31:0] inst_from_IFU,
    input  logic        br_taken,
    input  logic        br_taken_cancel,
    input  logic [31:0] br_target
);

    logic        fs_valid_q, fs_valid_d;
    logic [31:0] fs_pc_q, fs_pc_d;
    logic        rdata_fresh_q, rdata_fresh_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_inst_q, buf_inst_d;

    logic        br_stall;
    logic        fs_ready_go;
    logic        fs_allow_in;
    logic [31:0] nextpc;

    // A branch with unresolved operands in decode blocks wrong-path requests.
    assign br_stall    = br_taken & ~br_taken_cancel;
    assign fs_ready_go = 1'b1;
    assign fs_allow_in = ~fs_valid_q | (fs_ready_go & IDU_allow_in) | br_taken_cancel;
    assign nextpc      = br_taken_cancel ? br_target : fs_pc_q + 32'd4;

    assign inst_sram_en    = ~reset & fs_allow_in & ~br_stall;
    assign inst_sram_we    = 4'b0000;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wdata = 32'h0000_0000;

    assign IFU_to_IDU_valid = fs_valid_q & fs_ready_go & ~br_taken_cancel;
    assign pc_from_IFU      = fs_pc_q;
    assign inst_from_IFU    = buf_valid_q ? buf_inst_q : inst_sram_rdata;

    always_comb begin
        fs_valid_d    = fs_valid_q;
        fs_pc_d       = fs_pc_q;
        rdata_fresh_d = 1'b0;
        buf_valid_d   = buf_valid_q;
        buf_inst_d    = buf_inst_q;
        if (inst_sram_en) begin
            fs_pc_d       = nextpc;
            fs_valid_d    = 1'b1;
            rdata_fresh_d = 1'b1;
            buf_valid_d   = 1'b0;
        end else begin
            if ((fs_valid_q & IDU_allow_in) | br_taken_cancel) begin
                fs_valid_d  = 1'b0;
                buf_valid_d = 1'b0;
            end
            // SRAM output may change while stalled, so capture the word the cycle it arrives.
            if (fs_valid_q & rdata_fresh_q & ~IDU_allow_in & ~br_taken_cancel) begin
                buf_inst_d  = inst_sram_rdata;
                buf_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid_q    <= 1'b0;
            fs_pc_q       <= RESET_PC - 32'd4;
            rdata_fresh_q <= 1'b0;
            buf_valid_q   <= 1'b0;
            buf_inst_q    <= 32'h0000_0000;
        end else begin
            fs_valid_q    <= fs_valid_d;
            fs_pc_q       <= fs_pc_d;
            rdata_fresh_q <= rdata_fresh_d;
            buf_valid_q   <= buf_valid_d;
            buf_inst_q    <= buf_inst_d;
        end
    end

endmodule

// File: tb/tb_ifu_fetch_stage.sv
// Directed vector bench for ifu_fetch_stage with a 1-cycle-latency instruction SRAM model.
module tb_ifu_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata = 32'h0;
    logic        IDU_allow_in;
    logic        IFU_to_IDU_valid;
    logic [31:0] pc_from_IFU;
    logic [31:0] inst_from_IFU;
    logic        br_taken;
    logic        br_taken_cancel;
    logic [31:0] br_target;
    logic        corrupt;

    int n_checks = 0;
    int n_fail   = 0;

    ifu_fetch_stage #(.RESET_PC(32'h1c000000)) dut (
        .clk              (clk),
        .reset            (reset),
        .inst_sram_en     (inst_sram_en),
        .inst_sram_we     (inst_sram_we),
        .inst_sram_addr   (inst_sram_addr),
        .inst_sram_wdata  (inst_sram_wdata),
        .inst_sram_rdata  (inst_sram_rdata),
        .IDU_allow_in     (IDU_allow_in),
        .IFU_to_IDU_valid (IFU_to_IDU_valid),
        .pc_from_IFU      (pc_from_IFU),
        .inst_from_IFU    (inst_from_IFU),
        .br_taken         (br_taken),
        .br_taken_cancel  (br_taken_cancel),
        .br_target        (br_target)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ifn(input logic [31:0] a);
        return (a == 32'h1c000004) ? 32'h02800421 : (a ^ 32'h5a5a_0000);
    endfunction

    // SRAM model: word for last cycle's request; garbage when asked to corrupt an idle output.
    always @(posedge clk) begin
        if (inst_sram_en)
            inst_sram_rdata <= ifn(inst_sram_addr);
        else if (corrupt)
            inst_sram_rdata <= 32'hDEADBEEF;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        allow;
        logic        bt;
        logic        bc;
        logic [31:0] tgt;
        logic        cor;
        logic        e_en;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        chk_inst;
        logic [31:0] e_inst;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic allow, input logic bt, input logic bc,
                                input logic [31:0] tgt, input logic cor, input logic e_en,
                                input logic [31:0] e_addr, input logic e_valid, input logic [31:0] e_pc,
                                input logic chk_inst, input logic [31:0] e_inst);
        vec_t v;
        v.rst = rst; v.allow = allow; v.bt = bt; v.bc = bc; v.tgt = tgt; v.cor = cor;
        v.e_en = e_en; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        v.chk_inst = chk_inst; v.e_inst = e_inst;
        return v;
    endfunction

    vec_t vecs[23];

    initial begin
        logic [31:0] exp_pc;
        int          hs;

        reset = 1'b1; IDU_allow_in = 1'b1; br_taken = 1'b0; br_taken_cancel = 1'b0;
        br_target = 32'h0; corrupt = 1'b0;

        // Reset held for three cycles: no requests, nothing presented.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("rst_en", {31'b0, inst_sram_en}, 32'd0);
            check("rst_valid", {31'b0, IFU_to_IDU_valid}, 32'd0);
            check("rst_pc", pc_from_IFU, 32'h1bfffffc);
            $display("reset cycle %0d: en=%0b valid=%0b pc=%08h", i, inst_sram_en, IFU_to_IDU_valid, pc_from_IFU);
        end
        check("sram_we", {28'b0, inst_sram_we}, 32'd0);
        check("sram_wdata", inst_sram_wdata, 32'd0);

        //           rst allow bt bc tgt           cor en addr          valid pc            ci inst
        vecs[0]  = mk(0, 1, 0, 0, 32'h0,         0, 1, 32'h1c000000, 0, 32'h1bfffffc, 0, 32'h0);
        vecs[1]  = mk(0, 1, 0, 0, 32'h0,         0, 1, 32'h1c000004, 1, 32'h1c000000, 1, ifn(32'h1c000000));
        vecs[2]  = mk(0, 0, 0, 0, 32'h0,         1, 0, 32'h1c000008, 1, 32'h1c000004, 1, 32'h02800421);
        vecs[3]  = mk(0, 0, 0, 0, 32'h0,         1, 0, 32'h1c000008, 1, 32'h1c000004, 1, 32'h02800421);
        vecs[4]  = mk(0, 0, 0, 0, 32'h0,         1, 0, 32'h1c000008, 1, 32'h1c000004, 1, 32'h02800421);
        vecs[5]  = mk(0, 1, 0, 0, 32'h0,         0, 1, 32'h1c000008, 1, 32'h1c000004, 1, 32'h02800421);
        vecs[6]  = mk(0, 1, 0, 0, 32'h0,         0, 1, 32'h1c00000c, 1, 32'h1c000008, 1, ifn(32'h1c000008));
        vecs[7]  = mk(0, 1, 0, 0, 32'h0,         0, 1, 32'h1c000010, 1, 32'h1c00000c, 1, ifn(32'h1c00000c));
        vecs[8]  = mk(0, 1, 1, 1, 32'h1c000100,  0, 1, 32'h1c000100, 0, 32'h1c000010, 0, 32'h0);
        vecs[9]  = mk(0, 1, 0, 0, 32'h0,         0, 1, 32'h1c000104, 1, 32'h1c000100, 1, ifn(32'h1c000100));
        vecs[10] = mk(0, 1, 1, 0, 32'h0,         0, 0, 32'h1c000108, 1, 32'h1c000104, 1, ifn(32'h1c000104));
        vecs[11] = mk(0, 1, 1, 0, 32'h0,         0, 0, 32'h1c000108, 0, 32'h1c000104, 0, 32'h0);
        vecs[12] = mk(0, 1, 1, 1, 32'h1c000200,  0, 1, 32'h1c000200, 0, 32'h1c000104, 0, 32'h0);
        vecs[13] = mk(0, 1, 0, 0, 32'h0,         0, 1, 32'h1c000204, 1, 32'h1c000200, 1, ifn(32'h1c000200));
        vecs[14] = mk(0, 0, 0, 0, 32'h0,         0, 0, 32'h1c000208, 1, 32'h1c000204, 1, ifn(32'h1c000204));
        vecs[15] = mk(1, 0, 0, 0, 32'h0,         1, 0, 32'h1c000208, 1, 32'h1c000204, 1, ifn(32'h1c000204));
        vecs[16] = mk(1, 1, 0, 0, 32'h0,         0, 0, 32'h1c000000, 0, 32'h1bfffffc, 1, 32'hDEADBEEF);
        vecs[17] = mk(0, 1, 0, 0, 32'h0,         0, 1, 32'h1c000000, 0, 32'h1bfffffc, 1, 32'hDEADBEEF);
        vecs[18] = mk(0, 1, 0, 0, 32'h0,         0, 1, 32'h1c000004, 1, 32'h1c000000, 1, ifn(32'h1c000000));
        vecs[19] = mk(0, 1, 1, 1, 32'hfffffffc,  0, 1, 32'hfffffffc, 0, 32'h1c000004, 0, 32'h0);
        vecs[20] = mk(0, 1, 0, 0, 32'h0,         0, 1, 32'h00000000, 1, 32'hfffffffc, 1, ifn(32'hfffffffc));
        vecs[21] = mk(0, 0, 1, 1, 32'h1c000300,  0, 1, 32'h1c000300, 0, 32'h00000000, 0, 32'h0);
        vecs[22] = mk(0, 1, 0, 0, 32'h0,         0, 1, 32'h1c000304, 1, 32'h1c000300, 1, ifn(32'h1c000300));

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; IDU_allow_in = vecs[i].allow; br_taken = vecs[i].bt;
            br_taken_cancel = vecs[i].bc; br_target = vecs[i].tgt; corrupt = vecs[i].cor;
            #1;
            check($sformatf("v%0d_en", i), {31'b0, inst_sram_en}, {31'b0, vecs[i].e_en});
            check($sformatf("v%0d_addr", i), inst_sram_addr, vecs[i].e_addr);
            check($sformatf("v%0d_valid", i), {31'b0, IFU_to_IDU_valid}, {31'b0, vecs[i].e_valid});
            check($sformatf("v%0d_pc", i), pc_from_IFU, vecs[i].e_pc);
            if (vecs[i].chk_inst)
                check($sformatf("v%0d_inst", i), inst_from_IFU, vecs[i].e_inst);
            $display("vec %0d: rst=%0b allow=%0b bt=%0b bc=%0b -> en=%0b addr=%08h valid=%0b pc=%08h inst=%08h",
                     i, reset, IDU_allow_in, br_taken, br_taken_cancel, inst_sram_en, inst_sram_addr,
                     IFU_to_IDU_valid, pc_from_IFU, inst_from_IFU);
        end

        // Streaming with intermittent back-pressure: each pc presented once, in order.
        exp_pc = 32'h1c000304;
        hs = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            reset = 1'b0; br_taken = 1'b0; br_taken_cancel = 1'b0;
            IDU_allow_in = (i % 3 != 2);
            corrupt = ~IDU_allow_in;
            #1;
            check("stream_valid", {31'b0, IFU_to_IDU_valid}, 32'd1);
            check("stream_en", {31'b0, inst_sram_en}, {31'b0, IDU_allow_in});
            check("stream_pc", pc_from_IFU, exp_pc);
            check("stream_inst", inst_from_IFU, ifn(exp_pc));
            $display("stream %0d: allow=%0b pc=%08h inst=%08h", i, IDU_allow_in, pc_from_IFU, inst_from_IFU);
            if (IFU_to_IDU_valid && IDU_allow_in) begin
                hs++;
                exp_pc = exp_pc + 32'd4;
            end
        end
        check("stream_handshakes", hs, 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
